// File: rtl/mul_datapath_ctrl.sv
// Unsigned shift-free multiplier: P = A * B by repeated addition of A, B times.
// Operands arrive serially on data_in (A then B); result held with done until start drops.
module mul_datapath_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ACCUM  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic             w_eqz;

  assign w_eqz   = (r_b == '0);
  assign product = r_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LOAD_A;
      S_LOAD_A: w_state_next = S_LOAD_B;
      S_LOAD_B: w_state_next = S_ACCUM;
      S_ACCUM:  if (w_eqz) w_state_next = S_DONE;
      S_DONE:   if (!start) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    case (r_state)
      S_LOAD_A, S_LOAD_B, S_ACCUM: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default:                     ;
    endcase
  end

  // Datapath: P keeps its value outside LOAD_B/ACCUM so the last result survives in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      case (r_state)
        S_LOAD_A: r_a <= data_in;
        S_LOAD_B: begin
          r_b <= data_in;
          r_p <= '0;
        end
        S_ACCUM: begin
          if (!w_eqz) begin
            r_p <= r_p + r_a;
            r_b <= r_b - ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_datapath_ctrl.sv
// Scoreboard bench for mul_datapath_ctrl: expected product/latency queued at stimulus, checked at done.
module tb_mul_datapath_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] product;
  logic             done;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] prod;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt;
  int   errors_cnt;

  mul_datapath_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one operation starting from IDLE at a negedge. With hold=1, start stays high
  // through DONE; otherwise it is dropped while the operation runs.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    exp_t        e;
    exp_t        got;
    logic [31:0] full;
    int          cyc;
    int          limit;
    full   = {16'b0, a} * {16'b0, b};
    e.prod = full[WIDTH-1:0];
    e.lat  = 3 + int'(b);
    start  = 1'b1;
    step();
    check("busy_load_a", 32'(busy), 32'd1);
    data_in = a;
    sb_q.push_back(e);
    step();
    cyc = 1;
    data_in = b;
    if (!hold) start = 1'b0;
    step();
    cyc = 2;
    data_in = 16'(($urandom % 65535) + 1);
    check("busy_accum", 32'(busy), 32'd1);
    limit = e.lat + 8;
    while (!done && cyc < limit) begin
      step();
      cyc++;
    end
    got = sb_q.pop_front();
    if (!done) begin
      check("done_timeout", 32'(done), 32'd1);
    end else begin
      check("product", 32'(product), 32'(got.prod));
      check("latency", 32'(cyc), 32'(got.lat));
    end
    $display("op a=%0d b=%0d product=%0d cycles=%0d", a, b, product, cyc);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check("done_held", 32'(done), 32'd1);
        check("product_held", 32'(product), 32'(got.prod));
      end
      start = 1'b0;
    end
    step();
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_product_kept", 32'(product), 32'(got.prod));
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    @(negedge clk);
    step();
    check("reset_product", 32'(product), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    do_op(16'd17, 16'd5, 1'b0);
    do_op(16'd9, 16'd0, 1'b0);
    do_op(16'd0, 16'd3, 1'b0);
    do_op(16'hFFFF, 16'd2, 1'b0);

    // Reset during ACCUM aborts: A=7, B=10, a few accumulations in flight.
    start = 1'b1;
    step();
    data_in = 16'd7;
    step();
    data_in = 16'd10;
    start = 1'b0;
    step();
    step();
    step();
    check("accum_partial", 32'(product), 32'd14);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_product", 32'(product), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    check("abort_stays_idle", 32'(busy), 32'd0);

    do_op(16'd6, 16'd7, 1'b1);
    do_op(16'd3, 16'd4, 1'b0);

    for (int i = 0; i < 4; i++) begin
      do_op(16'($urandom), 16'($urandom_range(1, 20)), 1'b0);
    end

    if (sb_q.size() != 0) check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
